// File: rtl/counter_enable_ctrl.sv
// counter_enable_ctrl: button-driven run/idle/step FSM producing a prescaled single-cycle enable strobe
module counter_enable_ctrl #(
  parameter int DIV = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic stop,
  input  logic step,
  output logic enable,
  output logic running
);
  typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;
  localparam logic [CNT_W-1:0] TC = CNT_W'(DIV - 1);
  logic [2:0] s1, s2, s3;
  logic start_p, stop_p, step_p, tc, en_n;
  logic [CNT_W-1:0] pre, pre_n;
  state_t state, state_n;
  // two sync flops then one edge flop per button, packed as {start, stop, step}
  assign {start_p, stop_p, step_p} = s2 & ~s3;
  assign tc = pre == TC;
  always_comb begin
    state_n = IDLE;
    pre_n = pre;
    en_n = 1'b0;
    case (state)
      IDLE: begin
        state_n = stop_p ? IDLE : start_p ? RUN : step_p ? STEP : IDLE;
        pre_n = (!stop_p && start_p) ? '0 : pre;
        en_n = !stop_p && !start_p && step_p;
      end
      RUN: begin
        state_n = stop_p ? IDLE : RUN;
        pre_n = stop_p ? pre : tc ? '0 : pre + 1'b1;
        en_n = !stop_p && tc;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      state <= IDLE;
      pre <= '0;
      enable <= 1'b0;
      running <= 1'b0;
    end else begin
      s1 <= {start, stop, step};
      s2 <= s1;
      s3 <= s2;
      state <= state_n;
      pre <= pre_n;
      enable <= en_n;
      running <= state_n == RUN;
    end
  end
endmodule

// File: tb/tb_counter_enable_ctrl.sv
// tb_counter_enable_ctrl: random and directed button stimulus on DIV=4 and DIV=1 instances vs. a behavioural model
module tb_counter_enable_ctrl;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, step = 1'b0, armed = 1'b0;
  logic en4, run4, en1, run1;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  counter_enable_ctrl #(.DIV(4), .CNT_W(8)) u4 (.clk(clk), .reset(reset), .start(start), .stop(stop), .step(step), .enable(en4), .running(run4));
  counter_enable_ctrl #(.DIV(1), .CNT_W(8)) u1 (.clk(clk), .reset(reset), .start(start), .stop(stop), .step(step), .enable(en1), .running(run1));
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  // model: per button, history of levels seen at previous edges; mode 0 idle, 1 run, 2 step; k = edges since RUN entry
  int divs[2] = '{4, 1};
  int mode[2], k[2];
  logic m_en[2], m_run[2];
  logic [2:0] hist[3];
  always @(posedge clk) begin
    logic [2:0] cur;
    logic p_start, p_stop, p_step;
    cur = {start, stop, step};
    if (reset) begin
      for (int b = 0; b < 3; b++) hist[b] = '0;
      for (int d = 0; d < 2; d++) begin
        mode[d] = 0;
        m_en[d] = 1'b0;
        m_run[d] = 1'b0;
      end
    end else begin
      p_start = hist[2][1] && !hist[2][2];
      p_stop = hist[1][1] && !hist[1][2];
      p_step = hist[0][1] && !hist[0][2];
      for (int b = 0; b < 3; b++) hist[b] = {hist[b][1:0], cur[b]};
      for (int d = 0; d < 2; d++) begin
        m_en[d] = 1'b0;
        if (mode[d] == 0) begin
          if (!p_stop && p_start) begin
            mode[d] = 1;
            k[d] = 0;
          end else if (!p_stop && p_step) begin
            mode[d] = 2;
            m_en[d] = 1'b1;
          end
        end else if (mode[d] == 1) begin
          if (p_stop) mode[d] = 0;
          else begin
            k[d]++;
            m_en[d] = (k[d] % divs[d]) == 0;
          end
        end else mode[d] = 0;
        m_run[d] = mode[d] == 1;
      end
    end
  end
  always @(negedge clk) if (armed) begin
    chk("en4", en4, m_en[0]);
    chk("run4", run4, m_run[0]);
    chk("en1", en1, m_en[1]);
    chk("run1", run1, m_run[1]);
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int n;
    @(posedge clk);
    armed = 1'b1;
    repeat (2) begin
      @(negedge clk);
      {start, stop, step} = 3'($urandom);
      chk("rst_en", en4, 0);
      chk("rst_run", run4, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    {start, stop, step} = 3'b000;
    repeat (20) begin
      @(negedge clk);
      chk("idle_en", en4 | en1, 0);
      chk("idle_run", run4 | run1, 0);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !run4; i++) @(negedge clk);
    chk("run_up", run4, 1);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n += int'(en4);
    end
    chk("strobes20", n, 5);
    idle(2);
    stop = 1'b1;
    idle(1);
    stop = 1'b0;
    idle(4);
    chk("stopped", run4, 0);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      n += int'(en4);
    end
    chk("no_strobe_stopped", n, 0);
    start = 1'b1;
    idle(1);
    start = 1'b0;
    idle(12);
    stop = 1'b1;
    idle(1);
    stop = 1'b0;
    idle(6);
    n = 0;
    step = 1'b1;
    repeat (25) begin
      @(negedge clk);
      n += int'(en4);
    end
    step = 1'b0;
    chk("step_once", n, 1);
    idle(3);
    step = 1'b1;
    idle(1);
    start = 1'b1;
    idle(1);
    {start, step} = 2'b00;
    idle(8);
    chk("lockout_idle", run4, 0);
    {start, stop} = 2'b11;
    idle(1);
    {start, stop} = 2'b00;
    idle(8);
    chk("prio_idle", run4, 0);
    start = 1'b1;
    idle(1);
    start = 1'b0;
    idle(3);
    stop = 1'b1;
    idle(1);
    stop = 1'b0;
    idle(8);
    chk("stop_at_tc", run4, 0);
    start = 1'b1;
    idle(1);
    start = 1'b0;
    idle(7);
    chk("pre_reset_run", run4 & run1, 1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("mid_reset_run", run4 | run1, 0);
    idle(10);
    chk("post_reset_idle", run4 | run1, 0);
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) start = ~start;
      if ($urandom_range(7) == 0) stop = ~stop;
      if ($urandom_range(7) == 0) step = ~step;
      reset = $urandom_range(199) == 0;
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/counter_enable_ctrl.md
Name: counter_enable_ctrl

Overview:
Upstream control stage for the 4-bit synchronous counter. It turns three asynchronous push-button inputs (start, stop, step) into a clean, single-cycle, prescaled `enable` strobe for the counter's `enable` input.
- A run/idle/step state machine decides whether strobes are issued.
- A prescaler sets the strobe period in RUN.
- STEP issues exactly one strobe per button press.

Parameters:
- DIV, default 4: strobe period in clk cycles while in RUN. Legal range 1..2^CNT_W.
- CNT_W, default 8: prescaler register width.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  asynchronous button level; a rising edge requests RUN.
- stop  input  1  asynchronous button level; a rising edge requests IDLE.
- step  input  1  asynchronous button level; a rising edge requests one strobe.
- enable  output  1  registered single-cycle strobe; drives the counter's `enable` input.
- running  output  1  registered; high while the state is RUN.

Behaviour:
- Input conditioning:
  - Each button input passes through a 2-flop synchronizer, then a third flop for edge detection.
  - Edge pulse = sync2 & ~sync3, one cycle wide.
  - The FSM acts on the 3rd rising edge that samples the input high.
  - A held button produces one pulse only. There is no debounce filter; bounce is out of scope.
- Reset (reset=1 at a rising edge):
  - All sync/edge flops are cleared to 0.
  - state=IDLE, prescaler=0, enable=0, running=0.
  - Reset overrides all other activity, including mid-RUN and mid-STEP.
  - After reset is released, the block stays in IDLE until a new start or step edge arrives.
- States: IDLE, RUN, STEP. Any unused encoding returns to IDLE.
- Event priority, same cycle: stop_p > start_p > step_p.
- IDLE:
  - enable=0 and the prescaler is held.
  - stop_p: stay in IDLE.
  - start_p: go to RUN, prescaler←0, running←1.
  - step_p: go to STEP, enable←1 at the same edge.
- RUN:
  - The prescaler increments every edge.
  - When prescaler==DIV-1: prescaler←0 and enable←1. Otherwise enable←0.
  - The first strobe is high during cycle DIV after entry. Strobes repeat every DIV cycles.
  - With DIV=1, enable stays high continuously while in RUN.
  - stop_p: go to IDLE, enable←0, running←0. Stop wins over a coincident terminal count, so no strobe is issued at that edge.
  - start_p and step_p are ignored in RUN.
- STEP:
  - Lasts exactly one cycle; enable is high during that cycle.
  - On the next edge: go to IDLE, enable←0.
  - All button edges arriving during STEP are ignored (lockout).
- Arithmetic: the prescaler wraps only via the DIV-1 compare, never by natural overflow. Use CNT_W-bit unsigned compare.
- enable and running are pure flop outputs with no combinational path from the inputs.

Test Plan:
1. Reset values: reset=1 for 2 cycles with all buttons toggling → enable=0, running=0 throughout. After release with no button activity, both stay 0 for 20 cycles.
2. Start, DIV=4: pulse start high for 1 cycle → running=1 on the 3rd sampling edge. enable is high for 1 cycle every 4 cycles; 5 strobes counted over 20 cycles. The downstream counter advances 0→5.
3. Stop: press stop mid-period in RUN → running=0 and no further strobes. The prescaler freezes; a restart begins again from prescaler=0, with the first strobe 4 cycles after RUN entry.
4. Step in IDLE: hold step high for 20 cycles → exactly one enable pulse of 1 cycle. A second step press issued 1 cycle after the first edge is ignored (lockout). The counter increments by exactly 1.
5. Priority: in IDLE, start and stop rise together → remains IDLE, enable=0. In RUN, stop coincides with prescaler==3 → no strobe, state=IDLE.
6. Reset mid-RUN and DIV=1: assert reset during RUN → enable=0 and running=0 at the next edge, and the block remains IDLE after release. Rebuild with DIV=1 and press start → enable is continuously high while running.
